// File: rtl/clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module : clock_div_multi
// Brief  : Multi-channel runtime-programmable clock divider / tick generator.
//          Optional macro CLKDIV_CASCADE_EN chains channel k to channel k-1.
// Rev    : 1.0
// ============================================================================
module clock_div_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic                      clk_in,
  input  logic                      resetn_i,
  input  logic [NUM_CH-1:0]         en_i,
  input  logic [NUM_CH-1:0]         mode_i,
  input  logic [NUM_CH*CNT_W-1:0]   div_i,
  input  logic                      sync_i,
`ifdef CLKDIV_CASCADE_EN
  input  logic [NUM_CH-1:0]         cascade_i,
`endif
  output logic [NUM_CH-1:0]         clk_o,
  output logic [NUM_CH-1:0]         tick_o
);

  // Per-channel advance qualifier: 1 = count this cycle.
  logic [NUM_CH-1:0] adv;

`ifdef CLKDIV_CASCADE_EN
  assign adv[0] = 1'b1;
  if (NUM_CH > 1) begin : g_casc
    assign adv[NUM_CH-1:1] = ~cascade_i[NUM_CH-1:1] | tick_o[NUM_CH-2:0];
  end
  wire unused_casc0 = cascade_i[0];
`else
  assign adv = '1;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_sh_q, div_sh_d;
    logic [CNT_W-1:0] div_raw, div_eff;
    logic             mode_sh_q, mode_sh_d;
    logic             en_q, en_d;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             load;

    assign div_raw = div_i[k*CNT_W +: CNT_W];
    assign div_eff = (div_raw == '0) ? CNT_W'(1) : div_raw;
    assign load    = en_i[k] & (~en_q | sync_i);

    // run_q keeps a channel idle after reset until a genuine enable edge,
    // even if en_i is already high when reset releases.
    always_comb begin
      cnt_d     = cnt_q;
      div_sh_d  = div_sh_q;
      mode_sh_d = mode_sh_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      run_d     = run_q;
      en_d      = en_i[k];
      if (!en_i[k]) begin
        cnt_d = '0;
        clk_d = 1'b0;
        run_d = 1'b0;
      end else if (load) begin
        cnt_d     = '0;
        div_sh_d  = div_eff;
        mode_sh_d = mode_i[k];
        clk_d     = 1'b0;
        run_d     = 1'b1;
      end else if (!run_q) begin
        cnt_d = '0;
        clk_d = 1'b0;
      end else if (adv[k]) begin
        if (cnt_q == div_sh_q - CNT_W'(1)) begin
          // Output follows the mode of the period just finished.
          cnt_d     = '0;
          tick_d    = 1'b1;
          div_sh_d  = div_eff;
          mode_sh_d = mode_i[k];
          clk_d     = mode_sh_q ? 1'b1 : ~clk_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mode_sh_q) clk_d = 1'b0;
        end
      end else if (mode_sh_q) begin
        clk_d = 1'b0;
      end
    end

    always_ff @(posedge clk_in or negedge resetn_i) begin
      if (!resetn_i) begin
        cnt_q     <= '0;
        div_sh_q  <= CNT_W'(1);
        mode_sh_q <= 1'b0;
        en_q      <= 1'b1;
        run_q     <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        div_sh_q  <= div_sh_d;
        mode_sh_q <= mode_sh_d;
        en_q      <= en_d;
        run_q     <= run_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
      end
    end

    assign clk_o[k]  = clk_q;
    assign tick_o[k] = tick_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_clock_div_multi
// Brief  : Self-checking bench for clock_div_multi against a period-based model.
// Rev    : 1.0
// ============================================================================
module tb_clock_div_multi;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                    clk_in = 1'b0;
  logic                    resetn_i;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH-1:0]       mode_i;
  logic [NUM_CH*CNT_W-1:0] div_i;
  logic                    sync_i;
  logic [NUM_CH-1:0]       cascade_i;
  logic [NUM_CH-1:0]       clk_o;
  logic [NUM_CH-1:0]       tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  clock_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_in   (clk_in),
    .resetn_i (resetn_i),
    .en_i     (en_i),
    .mode_i   (mode_i),
    .div_i    (div_i),
    .sync_i   (sync_i),
`ifdef CLKDIV_CASCADE_EN
    .cascade_i(cascade_i),
`endif
    .clk_o    (clk_o),
    .tick_o   (tick_o)
  );

  always #5 clk_in = ~clk_in;

  // Model: each channel runs periods of length len starting at edge start;
  // a period ends when the elapsed edge count reaches len.
  int                m_t;
  int                m_start [NUM_CH];
  int                m_len   [NUM_CH];
  logic [NUM_CH-1:0] m_prev_en, m_act, m_mode, m_clk, m_tick;

  function automatic void model_reset();
    m_prev_en = '1;
    m_act     = '0;
    m_mode    = '0;
    m_clk     = '0;
    m_tick    = '0;
  endfunction

  function automatic void model_step();
    int nd;
    m_t++;
    for (int k = 0; k < NUM_CH; k++) begin
      nd = int'(div_i[k*CNT_W +: CNT_W]);
      if (nd == 0) nd = 1;
      if (!en_i[k]) begin
        m_act[k] = 1'b0; m_tick[k] = 1'b0; m_clk[k] = 1'b0;
      end else if (!m_prev_en[k] || sync_i) begin
        m_act[k] = 1'b1; m_start[k] = m_t; m_len[k] = nd; m_mode[k] = mode_i[k];
        m_tick[k] = 1'b0; m_clk[k] = 1'b0;
      end else if (m_act[k] && (m_t - m_start[k] == m_len[k])) begin
        m_tick[k] = 1'b1;
        m_clk[k]  = m_mode[k] ? 1'b1 : ~m_clk[k];
        m_start[k] = m_t; m_len[k] = nd; m_mode[k] = mode_i[k];
      end else begin
        m_tick[k] = 1'b0;
        if (m_mode[k] || !m_act[k]) m_clk[k] = 1'b0;
      end
      m_prev_en[k] = en_i[k];
    end
  endfunction

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic idle_all();
    en_i = '0; sync_i = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    int nt;
    resetn_i = 1'b0; en_i = '0; mode_i = '0; div_i = '0; sync_i = 1'b0; cascade_i = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    n_checks++;
    if (clk_o !== '0 || tick_o !== '0) begin
      n_fail++; $display("FAIL reset_init clk_o=%b tick_o=%b required 00/00", clk_o, tick_o);
    end
    resetn_i = 1'b1;
    div_i[0 +: CNT_W] = 8'd3; en_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL reset_prerun i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
    #2 resetn_i = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (clk_o !== '0 || tick_o !== '0) begin
      n_fail++; $display("FAIL reset_async clk_o=%b tick_o=%b required 00/00", clk_o, tick_o);
    end
    @(negedge clk_in);
    resetn_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_checks++;
      if (tick_o !== '0 || clk_o !== '0 || m_tick !== '0) begin
        n_fail++; $display("FAIL reset_hold i=%0d clk_o=%b tick_o=%b required 00/00", i, clk_o, tick_o);
      end
    end
    en_i = 2'b00; cycle();
    en_i = 2'b01; nt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (tick_o[0]) nt++;
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL reset_rerise i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
    n_checks++;
    if (nt !== 3) begin
      n_fail++; $display("FAIL reset_rerise_ticks got %0d required 3", nt);
    end
  endtask

  task automatic test_toggle();
    int first_rise, first_fall, n_rise, n_tick;
    logic prev;
    idle_all();
    mode_i = 2'b00; div_i[0 +: CNT_W] = 8'd4; en_i = 2'b01;
    first_rise = -1; first_fall = -1; n_rise = 0; n_tick = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (clk_o[0] && !prev) begin n_rise++; if (first_rise < 0) first_rise = i; end
      if (!clk_o[0] && prev && first_fall < 0) first_fall = i;
      prev = clk_o[0];
      if (tick_o[0]) begin
        n_tick++;
        n_checks++;
        if (i % 4 != 0) begin
          n_fail++; $display("FAIL toggle_tick_edge got edge %0d required multiple of 4", i);
        end
      end
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL toggle_model i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
    n_checks++;
    if (first_rise !== 4 || first_fall !== 8) begin
      n_fail++; $display("FAIL toggle_edges rise=%0d fall=%0d required 4/8", first_rise, first_fall);
    end
    n_checks++;
    if (n_rise !== 5 || n_tick !== 9) begin
      n_fail++; $display("FAIL toggle_counts rises=%0d ticks=%0d required 5/9", n_rise, n_tick);
    end
    en_i = 2'b00; cycle();
    n_checks++;
    if (clk_o !== '0 || tick_o !== '0) begin
      n_fail++; $display("FAIL toggle_disable clk_o=%b tick_o=%b required 00/00", clk_o, tick_o);
    end
  endtask

  task automatic test_pulse_n01();
    idle_all();
    mode_i = 2'b01; div_i[0 +: CNT_W] = 8'd0; en_i = 2'b01;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) div_i[0 +: CNT_W] = 8'd1;
      cycle();
      if (i >= 1) begin
        n_checks++;
        if (tick_o[0] !== 1'b1 || clk_o[0] !== 1'b1) begin
          n_fail++; $display("FAIL pulse_n01 i=%0d clk_o=%b tick_o=%b required 1/1", i, clk_o[0], tick_o[0]);
        end
      end
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL pulse_model i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
  endtask

  task automatic test_div_change();
    int ticks[$];
    idle_all();
    mode_i = 2'b01; div_i[0 +: CNT_W] = 8'd10; en_i = 2'b01;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (i == 3) div_i[0 +: CNT_W] = 8'd3;
      if (tick_o[0]) ticks.push_back(i);
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL divchg_model i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
    n_checks++;
    if (ticks.size() != 4 || ticks[0] != 10 || ticks[1] != 13 || ticks[2] != 16 || ticks[3] != 19) begin
      n_fail++; $display("FAIL divchg_ticks got %0d ticks first=%0d required 4 at 10,13,16,19",
                         ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
    end
  endtask

  task automatic test_sync();
    int pre, t0, t1;
    idle_all();
    mode_i = 2'b00; div_i = {8'd7, 8'd5}; en_i = 2'b11;
    pre = $urandom_range(20, 3);
    for (int i = 0; i < pre; i++) cycle();
    sync_i = 1'b1; cycle(); sync_i = 1'b0;
    t0 = -1; t1 = -1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (tick_o[0] && t0 < 0) t0 = i;
      if (tick_o[1] && t1 < 0) t1 = i;
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL sync_model i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
    n_checks++;
    if (t0 !== 5 || t1 !== 7) begin
      n_fail++; $display("FAIL sync_align ch0=%0d ch1=%0d required 5/7", t0, t1);
    end
  endtask

  task automatic test_boundary();
    int nt1;
    idle_all();
    mode_i = 2'b01; div_i = {8'd255, 8'd2}; en_i = 2'b11; nt1 = 0;
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (i == 0) mode_i = 2'b00;
      if (tick_o[1]) nt1++;
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL boundary_model i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
    n_checks++;
    if (nt1 !== 2) begin
      n_fail++; $display("FAIL boundary_ticks ch1=%0d required 2", nt1);
    end
  endtask

  task automatic test_random();
    idle_all();
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(15) == 0) en_i[k] = ~en_i[k];
        if ($urandom_range(7) == 0) mode_i[k] = 1'($urandom_range(1));
        if ($urandom_range(5) == 0) div_i[k*CNT_W +: CNT_W] = 8'($urandom_range(12));
      end
      sync_i = ($urandom_range(19) == 0);
      cycle();
      n_checks++;
      if (clk_o !== m_clk || tick_o !== m_tick) begin
        n_fail++; $display("FAIL random i=%0d clk_o=%b tick_o=%b required %b/%b", i, clk_o, tick_o, m_clk, m_tick);
      end
    end
    sync_i = 1'b0;
  endtask

`ifdef CLKDIV_CASCADE_EN
  task automatic test_cascade();
    int last, first_rise, nchk;
    logic prev;
    idle_all();
    cascade_i = 2'b10; mode_i = 2'b00; div_i = {8'd4, 8'd5}; en_i = 2'b11;
    last = -1; first_rise = -1; nchk = 0; prev = 1'b0;
    for (int i = 0; i < 130; i++) begin
      cycle();
      if (tick_o[1]) begin
        if (last >= 0) begin
          nchk++; n_checks++;
          if (i - last != 20) begin
            n_fail++; $display("FAIL cascade_gap got %0d required 20", i - last);
          end
        end
        last = i;
      end
      if (clk_o[1] && !prev) begin
        if (first_rise >= 0) begin
          n_checks++;
          if (i - first_rise != 40) begin
            n_fail++; $display("FAIL cascade_clk_period got %0d required 40", i - first_rise);
          end
        end
        first_rise = i;
      end
      prev = clk_o[1];
    end
    n_checks++;
    if (nchk < 4) begin
      n_fail++; $display("FAIL cascade_count got %0d gaps required >=4", nchk);
    end
    cascade_i = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_toggle();
    test_pulse_n01();
    test_div_change();
    test_sync();
    test_boundary();
    test_random();
`ifdef CLKDIV_CASCADE_EN
    test_cascade();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
